// File: rtl/shift_pkg.sv
// Shared mode encoding and mode-classification helpers for the shift/rotate pipeline.
package shift_pkg;

    typedef enum logic [2:0] {
        SHR  = 3'b000,
        SHRA = 3'b001,
        SHL  = 3'b010,
        ROR  = 3'b011,
        ROL  = 3'b100
    } shift_mode_e;

    function automatic logic is_right(input logic [2:0] mode);
        return (mode == SHR) || (mode == SHRA) || (mode == ROR);
    endfunction

    function automatic logic is_rotate(input logic [2:0] mode);
        return (mode == ROR) || (mode == ROL);
    endfunction

    // Encodings 101..111 are not operations; the data passes through untouched.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return mode <= ROL;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel step of 2**K positions plus its pipeline register and ready logic.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K     = 0,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [2:0]       i_mode,
    input  logic             i_sign,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [AMT_W-1:0] o_amt,
    output logic [2:0]       o_mode,
    output logic             o_sign,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_zero
);

    localparam int S = 1 << K;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    logic [2:0]       r_mode;
    logic             r_sign;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_fill;
    logic             w_load;

    // An empty stage takes new data even when everything below it is stalled.
    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    always_comb begin
        w_fill = '0;
        w_step = i_data;
        if ((i_mode == SHRA) && i_sign)
            w_fill = ~({WIDTH{1'b1}} >> S);
        if (i_amt[K] && is_shift_mode(i_mode)) begin
            if (is_rotate(i_mode))
                w_step = is_right(i_mode) ? ((i_data >> S) | (i_data << (WIDTH - S)))
                                          : ((i_data << S) | (i_data >> (WIDTH - S)));
            else if (is_right(i_mode))
                w_step = (i_data >> S) | w_fill;
            else
                w_step = i_data << S;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
            r_sign  <= 1'b0;
            r_tag   <= '0;
            r_zero  <= 1'b0;
        end else begin
            if (o_ready)
                r_valid <= i_valid;
            if (w_load) begin
                r_data <= w_step;
                r_amt  <= i_amt;
                r_mode <= i_mode;
                r_sign <= i_sign;
                r_tag  <= i_tag;
                r_zero <= (w_step == '0);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_mode  = r_mode;
    assign o_sign  = r_sign;
    assign o_tag   = r_tag;
    assign o_zero  = r_zero;

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined logarithmic shift/rotate unit: one registered barrel stage per amount bit,
// valid/ready handshaking on both ends and an opaque tag carried with each operation.
module shift_rotate_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:0] w_data [0:AMT_W];
    logic [AMT_W-1:0] w_amt  [0:AMT_W];
    logic [2:0]       w_mode [0:AMT_W];
    logic [TAG_W-1:0] w_tag  [0:AMT_W];
    logic [AMT_W:0]   w_sign;
    logic [AMT_W:0]   w_vld;
    logic [AMT_W:0]   w_rdy;
    logic [AMT_W:1]   w_zero;
    logic             w_unused_tail;

    // The sign of the original operand is captured once and rides along for SHRA fill.
    assign w_data[0] = in_data;
    assign w_amt[0]  = in_amt;
    assign w_mode[0] = in_mode;
    assign w_tag[0]  = in_tag;
    assign w_sign[0] = in_data[WIDTH-1];
    assign w_vld[0]  = in_valid;
    assign in_ready  = w_rdy[0];

    assign w_rdy[AMT_W] = out_ready;
    assign out_valid    = w_vld[AMT_W];
    assign out_data     = w_data[AMT_W];
    assign out_tag      = w_tag[AMT_W];
    assign out_zero     = w_zero[AMT_W];

    // Control carried past the last stage and zero flags of inner stages have no consumer.
    assign w_unused_tail = ^{w_amt[AMT_W], w_mode[AMT_W], w_sign[AMT_W], w_zero[AMT_W-1:1]};

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .clear_n (clear_n),
            .i_valid (w_vld[k]),
            .o_ready (w_rdy[k]),
            .i_data  (w_data[k]),
            .i_amt   (w_amt[k]),
            .i_mode  (w_mode[k]),
            .i_sign  (w_sign[k]),
            .i_tag   (w_tag[k]),
            .o_valid (w_vld[k+1]),
            .i_ready (w_rdy[k+1]),
            .o_data  (w_data[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_sign  (w_sign[k+1]),
            .o_tag   (w_tag[k+1]),
            .o_zero  (w_zero[k+1])
        );
    end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Randomised bench for shift_rotate_pipe with a queue-based reference model and directed literals.
module tb_shift_rotate_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    int checks   = 0;
    int failures = 0;
    int tag_seq  = 0;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t q[$];

    shift_rotate_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Whole-word reference: one shift by the full amount, no stage decomposition.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int amt, input logic [2:0] mode);
        logic signed [W-1:0] sd;
        sd = d;
        case (mode)
            3'd0:    return d >> amt;
            3'd1:    return W'(sd >>> amt);
            3'd2:    return d << amt;
            3'd3:    return (amt == 0) ? d : ((d >> amt) | (d << (W - amt)));
            3'd4:    return (amt == 0) ? d : ((d << amt) | (d >> (W - amt)));
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Model bookkeeping: results leave in acceptance order; reset discards everything in flight.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0)
                void'(q.pop_front());
            if (in_valid && in_ready)
                q.push_back('{ref_model(in_data, int'(in_amt), in_mode), in_tag});
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (in_ready !== ((q.size() < AW) || out_ready)) begin
            failures++;
            $display("FAIL in_ready got=%0b want=%0b occupancy=%0d", in_ready, (q.size() < AW) || out_ready, q.size());
        end
        if (clear_n && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL spurious_out got data=%0h tag=%0h want no result", out_data, out_tag);
            end else if (out_data !== q[0].data || out_tag !== q[0].tag || out_zero !== (q[0].data == '0)) begin
                failures++;
                $display("FAIL result got data=%0h zero=%0b tag=%0h want data=%0h zero=%0b tag=%0h",
                         out_data, out_zero, out_tag, q[0].data, q[0].data == '0, q[0].tag);
            end
        end
    end

    task automatic run_one(input string name, input logic [W-1:0] d, input logic [AW-1:0] amt,
                           input logic [2:0] mode, input logic [W-1:0] exp);
        int lat;
        in_valid = 1'b1; in_data = d; in_amt = amt; in_mode = mode;
        in_tag = TW'(tag_seq); tag_seq++; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'(AW));
        chk({name, "_data"}, 64'(out_data), 64'(exp));
        chk({name, "_zero"}, 64'(out_zero), 64'(exp == '0));
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input bit bp, output bit saw_stall);
        int  sent = 0;
        int  c    = 0;
        logic acc;
        saw_stall = 1'b0;
        while (sent < n && c < 5000) begin
            if (bp) begin
                in_valid  = 1'b1;
                in_data   = 32'h1357_9BDF * (sent + 1);
                in_amt    = AW'(sent * 3 + 1);
                in_mode   = 3'(sent % 5);
                in_tag    = TW'(sent);
                out_ready = !(c >= 3 && c <= 10);
            end else begin
                in_valid = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 5))
                    0:       in_data = '0;
                    1:       in_data = 32'h8000_0000;
                    2:       in_data = '1;
                    default: in_data = $urandom;
                endcase
                in_amt    = AW'($urandom);
                in_mode   = 3'($urandom_range(0, 7));
                in_tag    = TW'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clk); #1;
            if (acc) sent++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        bit stall;
        clear_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
        in_mode = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_zero",  64'(out_zero),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        clear_n = 1'b1;
        @(posedge clk); #1;

        run_one("ror1",      32'h8000_0001, 5'd1,  3'b011, 32'hC000_0000);
        run_one("rol4",      32'h8000_0001, 5'd4,  3'b100, 32'h0000_0018);
        run_one("shra31",    32'h8000_0000, 5'd31, 3'b001, 32'hFFFF_FFFF);
        run_one("shr31",     32'h8000_0000, 5'd31, 3'b000, 32'h0000_0001);
        run_one("shl31",     32'h0000_0002, 5'd31, 3'b010, 32'h0000_0000);
        run_one("pass111",   32'hDEAD_BEEF, 5'd9,  3'b111, 32'hDEAD_BEEF);
        run_one("ror0",      32'hDEAD_BEEF, 5'd0,  3'b011, 32'hDEAD_BEEF);
        run_one("shra_pos",  32'h7000_0000, 5'd4,  3'b001, 32'h0700_0000);

        stream(8, 1'b1, stall);
        chk("bp_in_ready_dropped", 64'(stall), 64'd1);
        drain("bp");

        stream(300, 1'b0, stall);
        drain("rand");

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_amt = AW'($urandom);
            in_mode = 3'($urandom_range(0, 4)); in_tag = TW'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_out_valid", 64'(out_valid), 64'd1);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data",  64'(out_data),  64'd0);
        chk("midrst_out_tag",   64'(out_tag),   64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        clear_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_one("after_rst", 32'h0000_00F0, 5'd4, 3'b000, 32'h0000_000F);
        repeat (8) @(posedge clk);
        #1;
        chk("after_rst_idle", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_rotate_pipe.md
# shift_rotate_pipe

- Parametrised, pipelined shift/rotate unit for the ALU datapath.
- Supersedes the fixed 32-bit combinational rotate-right operator.
- Supports five modes over a power-of-two operand width: logical right, arithmetic right, logical left, rotate right, rotate left.
- One logarithmic barrel stage per amount bit, each registered, with valid/ready flow control and a caller tag that travels with each operation.
- Sits between the operand registers and the ALU result mux, so multi-cycle shifts no longer limit the datapath clock.

## Interface
Parameters:
- WIDTH, 32, operand width; power of two, 8..64
- TAG_W, 4, width of the opaque tag carried alongside each operation
- AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridable

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clear_n  in  1  asynchronous active-low reset (the polarity and synchronicity are fixed)
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts the operation this cycle
- in_data  in  WIDTH  operand
- in_amt  in  AMT_W  shift/rotate amount
- in_mode  in  3  operation select (encoding in package)
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_zero  out  1  high when out_data is all zeros
- out_tag  out  TAG_W  tag of the presented result

## Operation
- Pipeline has AMT_W stages. Stage k applies a shift or rotate of 2^k when amount bit k is 1, and passes the data through otherwise.
- Each stage registers its data word, remaining amount bits, mode, sign bit, tag and valid.

Modes (3-bit):
- SHR (000): logical right, zero fill
- SHRA (001): arithmetic right; fill uses the sign bit of the original operand, captured at stage 0 and carried down the pipeline
- SHL (010): logical left, zero fill
- ROR (011): rotate right
- ROL (100): rotate left
- 101–111: pass-through; out_data equals in_data and no error is signalled

Boundary rules:
- Amount 0 returns in_data unchanged in every mode.
- Amount WIDTH-1 is the maximum; all amounts are exact, with no modulo ambiguity.
- out_zero is computed from the final stage result and registered with it.

Flow control:
- Per-stage valid with a ready chain. Stage k advances when stage k+1 is empty or advancing. The last stage advances when out_ready=1 or out_valid=0.
- Bubbles collapse: an empty stage accepts new data even while a downstream stage is stalled.
- in_ready = !v[0] | adv[0]. This is combinational from the stage valids and out_ready only, with no path from in_valid.
- A transfer happens on any cycle where valid and ready are both high. Results leave in acceptance order.

## Timing
- Latency is AMT_W cycles from an in_valid&in_ready edge to out_valid, with no backpressure (5 cycles for WIDTH=32).
- Throughput is one operation per cycle when out_ready is held high.
- Reset values: all stage valids 0, out_valid 0, out_data 0, out_zero 0, out_tag 0. in_ready reads 1 while clear_n is low and after release.
- Reset mid-operation discards every in-flight operation. No partial result is ever presented.
- While out_valid=1 and out_ready=0, out_data, out_zero and out_tag hold stable.
- Simultaneous accept and present in the same cycle is legal. A full pipeline with out_ready=1 sustains full rate.

## Structure
- Package shift_pkg holds:
  - the shift_mode_e enum: SHR, SHRA, SHL, ROR, ROL
  - the function is_right(mode)
  - the function is_rotate(mode)
- One sub-module, shift_stage: parametrised by WIDTH and stage index k. It contains one barrel step plus its pipeline register and valid/ready logic.
- The top level instantiates shift_stage AMT_W times in a generate loop.

## Test plan
Values are for WIDTH=32.
- ROR: 0x80000001, amt 1 -> 0xC0000000 after 5 cycles, out_zero=0.
- ROL: 0x80000001, amt 4 -> 0x00000018.
- Shift pair, amt 31 on 0x80000000: SHRA -> 0xFFFFFFFF; SHR -> 0x00000001; SHL of 0x00000002 by 31 -> 0x00000000 with out_zero=1.
- Backpressure:
  - Stream 8 ops with tags 0..7, out_ready=0 for cycles 3–10.
  - Expect in_ready to drop only once all 5 stages are full.
  - Expect results in tag order with out_data stable while stalled and no loss or duplication.
- Pass-through: mode 111, data 0xDEADBEEF, amt 9 -> 0xDEADBEEF. Mode ROR with amt 0 -> unchanged.
- Reset mid-stream: assert clear_n=0 with 3 ops in flight -> out_valid drops to 0 immediately. After release, the next op completes with the correct result and no stale output appears.
